// File: rtl/uart_rx_pkg.sv
// Shared constants, types and helpers for the UART receive sampling path.
package uart_rx_pkg;

    // Legal oversampling window and the fallback used when PRESCALE is out of range.
    localparam int unsigned PRESC_MIN  = 8;
    localparam int unsigned PRESC_MAX  = 32;
    localparam int unsigned PRESC_DFLT = 8;

    // Frame length in bit periods: start + 8 data + optional parity + stop.
    localparam int unsigned FRAME_LEN_PAR   = 11;
    localparam int unsigned FRAME_LEN_NOPAR = 10;

    // Bit indices within a frame.
    localparam int unsigned BIT_START = 0;
    localparam int unsigned BIT_DATA0 = 1;
    localparam int unsigned BIT_DATA7 = 8;

    // Where the current edge sits relative to the bit centre.
    typedef enum logic [2:0] {
        PhNone,
        PhCap0,
        PhCap1,
        PhCap2,
        PhVote
    } samp_phase_e;

    // The three raw samples taken around the bit centre.
    typedef struct packed {
        logic s0;
        logic s1;
        logic s2;
    } samp_regs_t;

    // 2-of-3 majority vote.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// N-flop synchroniser for the asynchronous RX line; resets to the idle level (1).
module uart_rx_sync #(
    // Number of flops in the chain; meaningful range is 2..4.
    parameter int unsigned Stages = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [Stages-1:0] sync_q;

    // Shift the raw line through the chain; synchronous reset to idle-high.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[Stages-2:0], d_i};
        end
    end

    assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/uart_rx_sample_timer.sv
// UART RX timing stage: synchronises the line, runs the oversample edge counter and the
// frame bit counter, and majority-votes three samples around each bit centre.
module uart_rx_sample_timer
    import uart_rx_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned PRESC_W     = 6,
    parameter int unsigned EDG_W       = 5,
    parameter int unsigned BIT_W       = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               RX_IN,
    input  logic [PRESC_W-1:0] PRESCALE,
    input  logic               PAR_EN,
    input  logic               CNT_EN,
    input  logic               DAT_SAMP_EN,
    output logic               RX_SYNC,
    output logic [EDG_W-1:0]   EDG_CNT,
    output logic [BIT_W-1:0]   BIT_CNT,
    output logic               SAMPLED_BIT,
    output logic               SAMPLE_DONE,
    output logic               BIT_DONE,
    output logic               PRESCALE_ERR
);

    // Common width for prescale/edge arithmetic, with one spare bit so P+2 never overflows.
    localparam int unsigned CW = ((PRESC_W > EDG_W) ? PRESC_W : EDG_W) + 1;

    logic               rx_sync;

    logic [CW-1:0]      presc_ext;
    logic               presc_legal;
    logic [CW-1:0]      p_eff;
    logic [CW-1:0]      p_last;
    logic [CW-1:0]      half;
    logic [CW-1:0]      edg_ext;
    logic               edg_wrap;
    logic [BIT_W-1:0]   bit_last;
    logic               bit_wrap;
    samp_phase_e        phase;

    logic [EDG_W-1:0]   edg_cnt_q, edg_cnt_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    samp_regs_t         samp_q, samp_d;
    logic               sampled_q, sampled_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    uart_rx_sync #(
        .Stages (SYNC_STAGES)
    ) u_sync (
        .clk_i  (CLK),
        .rst_ni (RST),
        .d_i    (RX_IN),
        .q_o    (rx_sync)
    );

    // Resolve the effective prescale P, its wrap point P-1 and the bit centre H = P/2.
    always_comb begin
        presc_ext   = CW'(PRESCALE);
        presc_legal = !PRESCALE[0] &&
                      (presc_ext >= CW'(PRESC_MIN)) &&
                      (presc_ext <= CW'(PRESC_MAX));
        p_eff       = presc_legal ? presc_ext : CW'(PRESC_DFLT);
        p_last      = p_eff - CW'(1);
        half        = p_eff >> 1;
        err_d       = !presc_legal;
    end

    // Wrap detection; ">=" keeps the counters bounded if P shrinks mid-frame.
    always_comb begin
        edg_ext  = CW'(edg_cnt_q);
        edg_wrap = (edg_ext >= p_last);
        bit_last = PAR_EN ? BIT_W'(FRAME_LEN_PAR - 1) : BIT_W'(FRAME_LEN_NOPAR - 1);
        bit_wrap = (bit_cnt_q >= bit_last);
    end

    // Edge and bit counter next state.
    always_comb begin
        edg_cnt_d = edg_cnt_q;
        bit_cnt_d = bit_cnt_q;
        if (!CNT_EN) begin
            edg_cnt_d = '0;
            bit_cnt_d = '0;
        end else if (edg_wrap) begin
            edg_cnt_d = '0;
            bit_cnt_d = bit_wrap ? '0 : bit_cnt_q + BIT_W'(1);
        end else begin
            edg_cnt_d = edg_cnt_q + EDG_W'(1);
        end
    end

    // Locate the current edge within the sampling window around the bit centre.
    always_comb begin
        phase = PhNone;
        if (edg_ext == half - CW'(1)) begin
            phase = PhCap0;
        end else if (edg_ext == half) begin
            phase = PhCap1;
        end else if (edg_ext == half + CW'(1)) begin
            phase = PhCap2;
        end else if (edg_ext == half + CW'(2)) begin
            phase = PhVote;
        end
    end

    // Capture three samples around the centre, then vote; everything holds when disabled.
    always_comb begin
        samp_d    = samp_q;
        sampled_d = sampled_q;
        done_d    = 1'b0;
        if (CNT_EN && DAT_SAMP_EN) begin
            unique case (phase)
                PhCap0: samp_d.s0 = rx_sync;
                PhCap1: samp_d.s1 = rx_sync;
                PhCap2: samp_d.s2 = rx_sync;
                PhVote: begin
                    sampled_d = maj3(samp_q.s0, samp_q.s1, samp_q.s2);
                    done_d    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            edg_cnt_q <= '0;
            bit_cnt_q <= '0;
            samp_q    <= '1;
            sampled_q <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            edg_cnt_q <= edg_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            samp_q    <= samp_d;
            sampled_q <= sampled_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign RX_SYNC      = rx_sync;
    assign EDG_CNT      = edg_cnt_q;
    assign BIT_CNT      = bit_cnt_q;
    assign SAMPLED_BIT  = sampled_q;
    assign SAMPLE_DONE  = done_q;
    assign BIT_DONE     = CNT_EN && edg_wrap;
    assign PRESCALE_ERR = err_q;

endmodule

// File: tb/tb_uart_rx_sample_timer.sv
// Bench for uart_rx_sample_timer: directed frame table, mid-frame reset, randomized frames,
// all checked against a frame-level model (counts, arithmetic on a sample history).
module tb_uart_rx_sample_timer;

    localparam int S = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_in;
    logic [5:0] presc;
    logic       par_en;
    logic       cnt_en;
    logic       samp_en;
    logic       rx_sync;
    logic [4:0] edg_cnt;
    logic [3:0] bit_cnt;
    logic       sampled;
    logic       sample_done;
    logic       bit_done;
    logic       presc_err;

    always #5 clk = ~clk;

    uart_rx_sample_timer #(
        .SYNC_STAGES (S),
        .PRESC_W     (6),
        .EDG_W       (5),
        .BIT_W       (4)
    ) dut (
        .CLK          (clk),
        .RST          (rst_n),
        .RX_IN        (rx_in),
        .PRESCALE     (presc),
        .PAR_EN       (par_en),
        .CNT_EN       (cnt_en),
        .DAT_SAMP_EN  (samp_en),
        .RX_SYNC      (rx_sync),
        .EDG_CNT      (edg_cnt),
        .BIT_CNT      (bit_cnt),
        .SAMPLED_BIT  (sampled),
        .SAMPLE_DONE  (sample_done),
        .BIT_DONE     (bit_done),
        .PRESCALE_ERR (presc_err)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: m_n counts enabled edges; edge index = m_n mod P, bit index = (m_n div P) mod F.
    int  m_p = 8;
    int  m_f = 10;
    int  m_n = 0;
    bit  m_sync_q[$];
    bit  m_seen[int];
    bit  m_sampled = 1'b1;
    bit  m_done    = 1'b0;
    bit  m_err     = 1'b0;

    function automatic bit legal(input logic [5:0] p);
        return (p[0] == 1'b0) && (p >= 6'd8) && (p <= 6'd32);
    endfunction

    function automatic int eff_p(input logic [5:0] p);
        return legal(p) ? int'(p) : 8;
    endfunction

    function automatic bit vote(input bit a, input bit b, input bit c);
        return (int'(a) + int'(b) + int'(c)) >= 2;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_n = 0;
        m_sync_q = {};
        for (int i = 0; i < S; i++) m_sync_q.push_back(1'b1);
        m_seen.delete();
        m_sampled = 1'b1;
        m_done    = 1'b0;
        m_err     = 1'b0;
    endtask

    // One clock edge: advance the model with the inputs that the edge sees.
    task automatic tick();
        bit pre;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            pre    = m_sync_q[0];
            m_err  = !legal(presc);
            m_done = 1'b0;
            if (cnt_en) begin
                m_seen[m_n] = pre;
                if (samp_en && ((m_n % m_p) == (m_p / 2 + 2))) begin
                    m_sampled = vote(m_seen[m_n-3], m_seen[m_n-2], m_seen[m_n-1]);
                    m_done    = 1'b1;
                end
                m_n++;
            end else begin
                m_n = 0;
                m_seen.delete();
            end
            m_sync_q.push_back(rx_in);
            void'(m_sync_q.pop_front());
        end
        #1;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".rx_sync"}, rx_sync, m_sync_q[0]);
        chk({tag, ".edg_cnt"}, edg_cnt, m_n % m_p);
        chk({tag, ".bit_cnt"}, bit_cnt, (m_n / m_p) % m_f);
        chk({tag, ".sampled"}, sampled, m_sampled);
        chk({tag, ".sample_done"}, sample_done, m_done);
        chk({tag, ".presc_err"}, presc_err, m_err);
        chk({tag, ".bit_done"}, bit_done, cnt_en && ((m_n % m_p) == m_p - 1));
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, ".rst_rx_sync"}, rx_sync, 1);
        chk({tag, ".rst_edg"}, edg_cnt, 0);
        chk({tag, ".rst_bit"}, bit_cnt, 0);
        chk({tag, ".rst_sampled"}, sampled, 1);
        chk({tag, ".rst_done"}, sample_done, 0);
        chk({tag, ".rst_err"}, presc_err, 0);
    endtask

    // Send one frame, RX aligned so RX_SYNC in counter state n carries frame bit n/P.
    // gpos >= 0 flips one sample; abort_at >= 0 resets the block in that state.
    task automatic run_frame(input string tag, input logic [5:0] presc_v, input bit par_v,
                             input logic [7:0] data, input int gpos, input bit samp_v,
                             input int p, input bit err_v, input int abort_at);
        int f;
        int total;
        int bd_cnt;
        int sd_cnt;
        bit line[];
        bit fbits[11];
        bit got[11];
        f     = par_v ? 11 : 10;
        total = f * p;
        for (int b = 0; b < 11; b++) begin
            fbits[b] = 1'b1;
            got[b]   = 1'b0;
        end
        fbits[0] = 1'b0;
        for (int i = 0; i < 8; i++) fbits[i+1] = data[i];
        if (par_v) fbits[9] = ^data;
        line = new[total + S];
        for (int i = 0; i < total + S; i++) line[i] = (i < total) ? fbits[i / p] : 1'b1;
        if (gpos >= 0) line[gpos] = ~line[gpos];

        presc   = presc_v;
        par_en  = par_v;
        cnt_en  = 1'b0;
        samp_en = 1'b0;
        m_p     = p;
        m_f     = f;
        for (int j = 0; j < S; j++) begin
            rx_in = line[j];
            tick();
        end
        chk({tag, ".err_flag"}, presc_err, err_v);

        bd_cnt = 0;
        sd_cnt = 0;
        for (int n = 0; n <= total; n++) begin
            cnt_en  = (n < total);
            samp_en = samp_v && (n < total);
            rx_in   = (n < total) ? line[n + S] : 1'b1;
            #1;
            check_all(tag);
            if (bit_done) bd_cnt++;
            if (sample_done) sd_cnt++;
            if ((n < total) && ((n % p) == p - 1)) got[n / p] = sampled;
            if (n == abort_at) begin
                rst_n = 1'b0;
                tick();
                check_reset_vals(tag);
                check_all({tag, ".in_rst"});
                rst_n   = 1'b1;
                cnt_en  = 1'b0;
                samp_en = 1'b0;
                rx_in   = 1'b1;
                tick();
                check_all({tag, ".post_rst"});
                return;
            end
            if (n < total) tick();
        end
        chk({tag, ".bit_done_pulses"}, bd_cnt, f);
        chk({tag, ".sample_done_pulses"}, sd_cnt, samp_v ? f : 0);
        if (samp_v) begin
            for (int b = 0; b < f; b++) chk({tag, ".frame_bit"}, got[b], fbits[b]);
        end
        cnt_en  = 1'b0;
        samp_en = 1'b0;
    endtask

    typedef struct {
        logic [5:0] presc;
        bit         par;
        logic [7:0] data;
        int         gpos;
        int         p;
        bit         err;
    } vec_t;

    vec_t tbl[7];

    initial begin
        tbl[0] = '{presc: 6'd8,  par: 1'b0, data: 8'h5A, gpos: -1,          p: 8,  err: 1'b0};
        tbl[1] = '{presc: 6'd16, par: 1'b1, data: 8'hC3, gpos: -1,          p: 16, err: 1'b0};
        tbl[2] = '{presc: 6'd32, par: 1'b0, data: 8'hA5, gpos: 1 * 32 + 16, p: 32, err: 1'b0};
        tbl[3] = '{presc: 6'd7,  par: 1'b0, data: 8'h3C, gpos: -1,          p: 8,  err: 1'b1};
        tbl[4] = '{presc: 6'd34, par: 1'b1, data: 8'h96, gpos: -1,          p: 8,  err: 1'b1};
        tbl[5] = '{presc: 6'd0,  par: 1'b0, data: 8'h01, gpos: -1,          p: 8,  err: 1'b1};
        tbl[6] = '{presc: 6'd30, par: 1'b1, data: 8'h7E, gpos: -1,          p: 30, err: 1'b0};

        // Reset hold with a low line, then release to idle.
        rst_n   = 1'b0;
        rx_in   = 1'b0;
        presc   = 6'd8;
        par_en  = 1'b0;
        cnt_en  = 1'b0;
        samp_en = 1'b0;
        model_reset();
        repeat (3) tick();
        check_reset_vals("hold");
        rst_n = 1'b1;
        rx_in = 1'b1;
        for (int i = 0; i < S + 2; i++) begin
            tick();
            check_all("idle");
        end
        chk("idle.rx_sync_high", rx_sync, 1);

        // Directed frames.
        for (int i = 0; i < 7; i++) begin
            run_frame($sformatf("tbl%0d", i), tbl[i].presc, tbl[i].par, tbl[i].data,
                      tbl[i].gpos, 1'b1, tbl[i].p, tbl[i].err, -1);
        end

        // Reset at EDG_CNT=5, BIT_CNT=4, then a clean frame.
        run_frame("abort", 6'd8, 1'b0, 8'h33, -1, 1'b1, 8, 1'b0, 4 * 8 + 5);
        run_frame("after_abort", 6'd8, 1'b0, 8'h33, -1, 1'b1, 8, 1'b0, -1);

        // Randomized frames, legal and illegal prescale, optional glitch.
        for (int r = 0; r < 20; r++) begin
            logic [5:0] pv;
            bit         par;
            bit         samp;
            logic [7:0] data;
            int         p;
            int         f;
            int         gpos;
            if ($urandom_range(0, 3) == 0) pv = 6'($urandom_range(0, 63));
            else pv = 6'(2 * $urandom_range(4, 16));
            par  = 1'($urandom_range(0, 1));
            samp = ($urandom_range(0, 3) != 0);
            data = 8'($urandom);
            p    = eff_p(pv);
            f    = par ? 11 : 10;
            gpos = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, f * p - 1)) : -1;
            run_frame($sformatf("rand%0d", r), pv, par, data, gpos, samp, p, !legal(pv), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/uart_rx_sample_timer.md
Name: uart_rx_sample_timer

Overview:
- Upstream timing/sampling stage of the UART receiver.
- Synchronises the raw RX line and runs the oversampling edge counter and the frame bit counter.
- Takes a 3-point majority vote around each bit centre.
- Supplies the sampled bit, edge count and bit count that the RX FSM, deserializer, parity checker and stop checker consume.

Parameters:
- SYNC_STAGES, 2, number of flops in the RX_IN synchroniser (legal 2..4).
- PRESC_W, 6, width of PRESCALE.
- EDG_W, 5, width of EDG_CNT; must hold max prescale minus 1 (31).
- BIT_W, 4, width of BIT_CNT.

Ports:
- CLK  in  1  RX oversampling clock.
- RST  in  1  synchronous active-low reset: sampled on the CLK rising edge; when 0, all state is reset on that edge.
- RX_IN  in  1  raw asynchronous serial line, idle high.
- PRESCALE  in  PRESC_W  oversampling ratio; legal values are even, 8..32.
- PAR_EN  in  1  parity bit present in frame.
- CNT_EN  in  1  from RX FSM: run counters (high from start detect to frame end).
- DAT_SAMP_EN  in  1  from RX FSM: enable majority sampling.
- RX_SYNC  out  1  synchronised RX line, for start-edge detection by the FSM.
- EDG_CNT  out  EDG_W  oversample edge index within the current bit.
- BIT_CNT  out  BIT_W  bit index within the frame: 0 = start, 1..8 = data, then parity (if PAR_EN), then stop.
- SAMPLED_BIT  out  1  majority-voted bit value.
- SAMPLE_DONE  out  1  one-cycle pulse when SAMPLED_BIT has just been updated.
- BIT_DONE  out  1  one-cycle pulse, combinational: EDG_CNT == P-1 and CNT_EN.
- PRESCALE_ERR  out  1  registered; high while PRESCALE is illegal.

Behaviour:
- Reset (RST=0 at a CLK edge):
  - All synchroniser flops and RX_SYNC = 1.
  - EDG_CNT, BIT_CNT = 0.
  - s0, s1, s2 = 1; SAMPLED_BIT = 1.
  - SAMPLE_DONE = 0; PRESCALE_ERR = 0.
  - Reset mid-frame aborts the frame with no partial pulses.
- Synchroniser:
  - RX_SYNC is RX_IN delayed by SYNC_STAGES edges.
  - All sampling uses RX_SYNC only.
- Effective prescale P:
  - P = PRESCALE when PRESCALE is even and 8 <= PRESCALE <= 32.
  - Otherwise P = 8, and PRESCALE_ERR = 1 on the next edge.
  - H = P/2.
- Edge counter:
  - CNT_EN=0: EDG_CNT and BIT_CNT are forced to 0 on the next edge.
  - CNT_EN=1: EDG_CNT increments each edge; at P-1 it wraps to 0 and BIT_CNT increments.
- Bit counter:
  - Frame length F = 11 if PAR_EN, else 10.
  - At EDG_CNT==P-1 with BIT_CNT==F-1, BIT_CNT wraps to 0; back-to-back frames need no idle.
- PRESCALE or PAR_EN changing mid-frame is illegal.
  - Block requirement: EDG_CNT >= new P-1 is treated as the wrap point; counters must not run away.
- Sampling (only when CNT_EN && DAT_SAMP_EN):
  - Capture s0 at the edge where EDG_CNT==H-1, s1 at H, s2 at H+1.
  - At the edge where EDG_CNT==H+2: SAMPLED_BIT <= majority(s0,s1,s2) and SAMPLE_DONE <= 1 for exactly one cycle.
  - SAMPLED_BIT is stable from EDG_CNT==H+3 through P-1 and beyond, until the next update.
  - For P=8 the update lands at EDG_CNT=6, so the value is valid at EDG_CNT=7, when the deserializer shifts.
- DAT_SAMP_EN=0: s regs and SAMPLED_BIT hold; SAMPLE_DONE=0.
- Latency, RX_IN edge to effect: SYNC_STAGES cycles to RX_SYNC, plus the capture cycle.

Decomposition:
- Package uart_rx_pkg:
  - PRESC_MIN=8, PRESC_MAX=32, PRESC_DFLT=8.
  - FRAME_LEN_PAR=11, FRAME_LEN_NOPAR=10.
  - localparam BIT_START=0, BIT_DATA0=1, BIT_DATA7=8.
  - Function maj3.
- Sub-module uart_rx_sync: parameterised N-flop synchroniser with synchronous active-low reset to 1.

Test Plan:
- Reset hold, then release with RX_IN=1 and CNT_EN=0 -> RX_SYNC=1, EDG_CNT=0, BIT_CNT=0, SAMPLED_BIT=1, no pulses.
- PRESCALE=8, PAR_EN=0, frame 0x5A sent LSB first with CNT_EN/DAT_SAMP_EN held -> EDG_CNT cycles 0..7 and BIT_CNT 0..9 then back to 0; SAMPLE_DONE at EDG_CNT=6 of every bit; SAMPLED_BIT at EDG_CNT=7 reads 0, 0,1,0,1,1,0,1,0, 1.
- PRESCALE=16, PAR_EN=1, 0xC3 frame with parity 0 -> updates at EDG_CNT=10; 11 BIT_DONE pulses; BIT_CNT wraps after 10.
- PRESCALE=32, one-cycle glitch to 0 at EDG_CNT=16 of a '1' data bit -> SAMPLED_BIT stays 1 (majority 1,0,1).
- PRESCALE=7 and PRESCALE=34 -> PRESCALE_ERR=1; behaviour identical to P=8 (SAMPLE_DONE at EDG_CNT=6).
- Reset asserted at EDG_CNT=5, BIT_CNT=4 mid-frame -> next edge all outputs at reset values, SAMPLE_DONE never pulses; the following frame decodes correctly.
